// File: rtl/joystick_chain_reader.sv
// Scans a daisy-chained PISO chain, debounces, applies autofire; joy_o/frame_stb update one edge after the DONE tick.
// No backpressure: progress is paced by ce alone, and ce low freezes every state element.
module joystick_chain_reader #(
  parameter int CHANNELS = 2,
  parameter int BITS = 8,
  parameter int GAP = 64,
  parameter int DEBOUNCE = 2,
  parameter logic [BITS-1:0] AF_MASK = BITS'(8'h30),
  parameter int AF_FRAMES = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [CHANNELS-1:0]      af_en,
  output logic                     joyLd,
  output logic                     joyCk,
  input  logic                     joyD,
  output logic [CHANNELS*BITS-1:0] joy_o,
  output logic                     frame_stb
);

  localparam int N   = CHANNELS * BITS;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;
  localparam int GW  = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int AFW = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
  localparam int HW  = (DEBOUNCE > 1) ? DEBOUNCE - 1 : 1;

  // One-hot so the pin outputs are single flop taps and cannot glitch.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    LOAD  = 5'b00010,
    CK_LO = 5'b00100,
    CK_HI = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [KW-1:0]       k_q, k_d;
  logic [N-1:0]        shift_q, shift_d;
  logic [HW-1:0][N-1:0] hist_q, hist_d;
  logic [N-1:0]        deb_q, deb_d;
  logic [AFW-1:0]      af_cnt_q, af_cnt_d;
  logic                phase_q, phase_d;
  logic [N-1:0]        joy_o_q, joy_o_d;
  logic                frame_stb_q, frame_stb_d;

  logic [N-1:0]        raw;
  logic [N-1:0]        all_one;
  logic [N-1:0]        all_zero;
  logic [N-1:0]        af_kill;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      k_q         <= '0;
      shift_q     <= '0;
      hist_q      <= '0;
      deb_q       <= '0;
      af_cnt_q    <= '0;
      phase_q     <= 1'b0;
      joy_o_q     <= '0;
      frame_stb_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      hist_q      <= hist_d;
      deb_q       <= deb_d;
      af_cnt_q    <= af_cnt_d;
      phase_q     <= phase_d;
      joy_o_q     <= joy_o_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    k_d     = k_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (gap_q == GW'(GAP - 1)) begin
            gap_d   = '0;
            state_d = LOAD;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        LOAD: begin
          k_d     = '0;
          state_d = CK_LO;
        end
        CK_LO: state_d = CK_HI;
        CK_HI: begin
          if (k_q == KW'(N - 1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = CK_LO;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    joyLd = ~state_q[1];
    joyCk = ~state_q[2];
  end

  // Autofire suppression uses the phase that was current before this frame's toggle.
  always_comb begin
    af_kill = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < BITS; b++) begin
        af_kill[c*BITS + b] = af_en[c] & AF_MASK[b] & phase_q;
      end
    end
  end

  always_comb begin
    shift_d     = shift_q;
    hist_d      = hist_q;
    deb_d       = deb_q;
    af_cnt_d    = af_cnt_q;
    phase_d     = phase_q;
    joy_o_d     = joy_o_q;
    frame_stb_d = 1'b0;
    raw         = ~shift_q;
    all_one     = raw;
    all_zero    = ~raw;
    for (int i = 0; i < DEBOUNCE - 1; i++) begin
      all_one  = all_one & hist_q[i];
      all_zero = all_zero & ~hist_q[i];
    end
    if (ce) begin
      if (state_q == CK_LO) begin
        shift_d[KW'(N - 1) - k_q] = joyD;
      end
      if (state_q == DONE) begin
        hist_d[0] = raw;
        for (int i = 1; i < HW; i++) begin
          hist_d[i] = hist_q[i-1];
        end
        deb_d = all_one | (deb_q & ~all_zero);
        if (af_cnt_q == AFW'(AF_FRAMES - 1)) begin
          af_cnt_d = '0;
          phase_d  = ~phase_q;
        end else begin
          af_cnt_d = af_cnt_q + 1'b1;
        end
        joy_o_d     = deb_d & ~af_kill;
        frame_stb_d = 1'b1;
      end
    end
  end

  assign joy_o     = joy_o_q;
  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_joystick_chain_reader.sv
// Directed bench for joystick_chain_reader at default parameters with a 74HC165 chain model.
module tb_joystick_chain_reader;

  logic        clk_sys;
  logic        reset;
  logic        ce;
  logic [1:0]  af_en;
  logic        joyLd;
  logic        joyCk;
  logic        joyD;
  logic [15:0] joy_o;
  logic        frame_stb;

  joystick_chain_reader dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce        (ce),
    .af_en     (af_en),
    .joyLd     (joyLd),
    .joyCk     (joyCk),
    .joyD      (joyD),
    .joy_o     (joy_o),
    .frame_stb (frame_stb)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Chain model: active-low buttons, first shifted bit is pat[15].
  logic [15:0] pat;
  logic [15:0] sr;
  logic        prev_ck;
  always @(posedge clk_sys) begin
    if (!joyLd) sr <= pat;
    else if (joyCk && !prev_ck) sr <= {sr[14:0], 1'b1};
    prev_ck <= joyCk;
  end
  assign joyD = sr[15];

  int   cyc = 0;
  int   ck_falls = 0;
  int   ld_falls = 0;
  logic pck = 1'b1;
  logic pld = 1'b1;
  always @(posedge clk_sys) begin
    cyc++;
    if (pck && !joyCk) ck_falls++;
    if (pld && !joyLd) ld_falls++;
    pck = joyCk;
    pld = joyLd;
  end

  logic ce_run;
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk_sys);
      ce = ce_run & ~ce;
    end
  end

  int checks = 0;
  int errors = 0;
  int nframe = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 1000) begin
      @(negedge clk_sys);
      n++;
      if (frame_stb) got = 1'b1;
    end
    if (got) nframe++;
    check({tag, "_stb"}, 32'(got), 32'd1);
  endtask

  task automatic wait_ck(input int target, input string tag);
    int n;
    n = 0;
    while (!(ck_falls >= target && joyCk == 1'b0) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(ck_falls >= target && joyCk == 1'b0), 32'd1);
  endtask

  int t0, c0, l0, ticks, changes, stbs;
  logic        s_ck, s_ld;
  logic [15:0] s_jo;
  logic [15:0] af_exp;
  int db_raw[7] = '{0, 1, 0, 1, 1, 0, 0};
  int db_exp[7] = '{0, 0, 0, 0, 1, 1, 0};

  initial begin
    reset  = 1'b1;
    af_en  = 2'b00;
    pat    = 16'hFFFF;
    ce_run = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_joyLd", 32'(joyLd), 32'd1);
    check("rst_joyCk", 32'(joyCk), 32'd1);
    check("rst_joy_o", 32'(joy_o), 32'h0);
    check("rst_stb", 32'(frame_stb), 32'd0);
    reset  = 1'b0;
    ce_run = 1'b1;

    // Protocol timing between consecutive strobes
    wait_frame("f1");
    t0 = cyc; c0 = ck_falls; l0 = ld_falls;
    wait_frame("f2");
    check("period_clks", 32'(cyc - t0), 32'd196);
    check("ck_pulses", 32'(ck_falls - c0), 32'd16);
    check("ld_pulses", 32'(ld_falls - l0), 32'd1);

    // Bit mapping (two frames each to satisfy debounce)
    pat = 16'hFFFE;
    wait_frame("map1"); check("map_last_hold", 32'(joy_o), 32'h0000);
    wait_frame("map2"); check("map_last", 32'(joy_o), 32'h0001);
    pat = 16'h7FFF;
    wait_frame("map3"); check("map_first_hold", 32'(joy_o), 32'h0001);
    wait_frame("map4"); check("map_first", 32'(joy_o), 32'h8000);
    pat = 16'hFFFF;
    wait_frame("rel1"); check("release_hold", 32'(joy_o), 32'h8000);
    wait_frame("rel2"); check("release", 32'(joy_o), 32'h0000);

    // Debounce on channel 0 bit 3
    for (int i = 0; i < 7; i++) begin
      pat = (db_raw[i] != 0) ? 16'hFFF7 : 16'hFFFF;
      wait_frame("deb");
      check($sformatf("deb_%0d", i), 32'(joy_o), (db_exp[i] != 0) ? 32'h0008 : 32'h0000);
    end

    // Autofire: ch0 bit4, ch1 bit4 and ch0 bit0 held, autofire on ch0 only
    af_en = 2'b01;
    pat   = ~16'h1011;
    for (int i = 0; i < 10; i++) begin
      wait_frame("af");
      af_exp = 16'h1001 | (((((nframe - 1) / 4) % 2) == 0) ? 16'h0010 : 16'h0000);
      if (i == 0) af_exp = 16'h0000;
      check($sformatf("af_frame%0d", nframe), 32'(joy_o), 32'(af_exp));
    end

    // ce stall mid-shift
    af_en = 2'b00;
    pat   = ~16'hA5C3;
    wait_frame("st0");
    check("stall_pre", 32'(joy_o), 32'h1011);
    c0 = ck_falls;
    wait_ck(c0 + 5, "stall_reach");
    ce_run = 1'b0;
    repeat (2) @(negedge clk_sys);
    s_ck = joyCk; s_ld = joyLd; s_jo = joy_o;
    changes = 0; stbs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys);
      if (joyCk !== s_ck || joyLd !== s_ld || joy_o !== s_jo) changes++;
      if (frame_stb) stbs++;
    end
    check("stall_changes", 32'(changes), 32'd0);
    check("stall_stb", 32'(stbs), 32'd0);
    ce_run = 1'b1;
    wait_frame("st1");
    check("stall_data", 32'(joy_o), 32'hA5C3);

    // Reset during CK_LO with k=5
    c0 = ck_falls;
    wait_ck(c0 + 6, "rst_mid_reach");
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check("rstm_joyLd", 32'(joyLd), 32'd1);
    check("rstm_joyCk", 32'(joyCk), 32'd1);
    check("rstm_joy_o", 32'(joy_o), 32'h0);
    check("rstm_stb", 32'(frame_stb), 32'd0);
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys);
      if (ce) ticks++;
      @(negedge clk_sys);
      if (!joyLd) break;
    end
    check("rstm_gap_ticks", 32'(ticks), 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joystick_chain_reader.md
Name: joystick_chain_reader

Overview:
- Parametrised successor to the single-pair serial joystick reader.
- Scans a daisy-chained 74HC165-style parallel-in/serial-out shift-register chain carrying CHANNELS controllers of BITS buttons each.
- Adds the following over the single-pair reader: configurable chain length, frame gap, multi-frame debounce, per-channel autofire, and a frame-complete strobe.
- Sits between the board joystick connector pins and the console/MCU joystick inputs; runs on clk_sys, paced by an external clock enable.

Parameters:
- CHANNELS, 2, number of controllers in the chain (1..8).
- BITS, 8, buttons per controller (1..16); chain length N = CHANNELS*BITS.
- GAP, 64, idle ce ticks between frames (>=1).
- DEBOUNCE, 2, consecutive identical raw frames required before an output bit changes (1..4; 1 = no debounce).
- AF_MASK, 8'h30, per-controller button mask (BITS wide) of autofire-capable bits, applied to every channel.
- AF_FRAMES, 4, frames per autofire half-period (>=1).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; all FSM progress occurs only on clk_sys edges with ce=1
- af_en  in  CHANNELS  per-channel autofire enable
- joyLd  out  1  chain parallel-load, active low
- joyCk  out  1  chain shift clock
- joyD  in  1  chain serial data, active low (0 = pressed)
- joy_o  out  CHANNELS*BITS  debounced active-high buttons; channel c at [c*BITS +: BITS]; bit BITS-1 is the first bit shifted out of that channel
- frame_stb  out  1  one clk_sys pulse when joy_o may have updated

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - FSM to IDLE, gap counter 0; joyLd=1, joyCk=1.
  - joy_o=0, frame_stb=0.
  - Debounce history cleared to all-released; autofire phase=0, autofire frame counter=0.
- FSM states, advancing on ce ticks only:
  - IDLE: joyLd=1, joyCk=1; count GAP ticks, then go to LOAD.
  - LOAD: joyLd=0 for exactly 1 tick; joyCk=1; bit index k=0; go to CK_LO.
  - CK_LO: joyCk=0, joyLd=1; sample joyD into shift register position N-1-k; go to CK_HI.
  - CK_HI: joyCk=1; if k==N-1 go to DONE, else k=k+1 and go to CK_LO.
  - DONE: raw = ~shift register (inverted to active-high); push raw into debounce history; go to IDLE.
- Sampling order:
  - The first sampled bit (k=0) lands in joy_o[N-1], i.e. the MSB of the last channel field.
  - Wiring convention: channel CHANNELS-1 is nearest the FPGA.
- Frame length: GAP + 1 + 2N + 1 ce ticks. With defaults: 64+1+32+1 = 98 ticks.
- Debounce:
  - deb bit = the common value of the last DEBOUNCE raw frames if they all agree; otherwise the previous deb bit is held.
  - Evaluated once per DONE, per bit independently.
- Autofire:
  - Frame counter increments at each DONE; at AF_FRAMES-1 it wraps to 0 and the autofire phase toggles.
  - joy_o bit = deb bit AND NOT(af_en[c] AND AF_MASK[b] AND phase).
  - Non-masked bits and channels with af_en=0 pass deb unchanged.
  - af_en is sampled at DONE only.
- Output timing:
  - joy_o and frame_stb update on the clk_sys edge after the DONE tick.
  - frame_stb is high exactly one clk_sys cycle per frame, regardless of ce duty cycle.
- ce held low: all outputs and state freeze, frame_stb stays 0.
- Counter widths:
  - k uses clog2(N) bits.
  - Gap counter uses clog2(GAP+1) bits.
  - No counter overflows for legal parameter values.

Test Plan:
- Reset mid-frame: assert reset during CK_LO with k=5 -> next cycle joyLd=1, joyCk=1, joy_o=0; the next LOAD occurs exactly GAP ce ticks later.
- Protocol timing (defaults, ce every 2 clocks): one frame gives 1 joyLd low tick, 16 joyCk low pulses, frame_stb period 98 ticks = 196 clocks.
- Bit mapping: the chain model presents 16'hFFFE (only the last-shifted bit low); DEBOUNCE=1 -> joy_o=16'h0001. A model presenting only the first-shifted bit low -> joy_o=16'h8000.
- Debounce, DEBOUNCE=2: raw sequence for one bit 0,1,0,1,1 -> joy_o bit after each frame 0,0,0,0,1. Release after two 0 frames -> 0.
- Autofire: af_en=2'b01, channel 0 bit 4 held, AF_FRAMES=4 -> joy_o[4] pattern 1,1,1,1,0,0,0,0 repeating. The same bit on channel 1 (joy_o[12]) stays 1. Bit 0 of channel 0 is unaffected.
- ce stall: hold ce=0 for 1000 clocks mid-SHIFT -> joyCk/joyLd/joy_o constant, no frame_stb; resuming completes the frame with correct data.
